// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous RAM port (1-cycle read latency)
// between the CPU data interface (fixed priority) and an auxiliary
// requester. A bounded CPU grant streak guarantees the aux side progress.
module dmem_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_adr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_gnt,
  output logic          aux_rvalid,
  output logic [DW-1:0] aux_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            SW   = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);

  // IDLE: nothing returning; CPU_RD / AUX_RD: that requester's read data
  // is on mem_rdata this cycle (the port is free to issue again).
  typedef enum logic [1:0] {IDLE, CPU_RD, AUX_RD} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          cpu_cand;
  logic          cpu_win;
  logic          aux_win;

  // Arbitration, RAM drive, handshake outputs and next-state selection.
  always_comb begin
    cpu_cand   = 1'b0;
    cpu_win    = 1'b0;
    aux_win    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_adr    = '0;
    mem_wdata  = '0;
    cpu_stall  = 1'b0;
    cpu_rdata  = '0;
    aux_gnt    = 1'b0;
    aux_rvalid = 1'b0;
    aux_rdata  = '0;
    state_nxt  = IDLE;
    streak_nxt = '0;

    if (!reset) begin
      // In CPU_RD the held CPU read is being completed, not re-issued.
      cpu_cand = (cpu_rd | cpu_wr) && (state != CPU_RD);
      cpu_win  = cpu_cand && !(aux_req && (streak == SMAX));
      aux_win  = aux_req && !cpu_win;

      if (cpu_win) begin
        mem_en    = 1'b1;
        mem_we    = cpu_wr;
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
      end else if (aux_win) begin
        mem_en    = 1'b1;
        mem_we    = aux_we;
        mem_adr   = aux_adr;
        mem_wdata = aux_wdata;
      end

      // Only a granted store finishes without waiting.
      cpu_stall = cpu_cand && !(cpu_win && cpu_wr);
      aux_gnt   = aux_win;

      if (state == CPU_RD) cpu_rdata = mem_rdata;
      if (state == AUX_RD) begin
        aux_rvalid = 1'b1;
        aux_rdata  = mem_rdata;
      end

      if (cpu_win && cpu_rd)       state_nxt = CPU_RD;
      else if (aux_win && !aux_we) state_nxt = AUX_RD;
      else                         state_nxt = IDLE;

      // Count CPU grants that cost a waiting aux a slot.
      if (!aux_req || aux_win)              streak_nxt = '0;
      else if (cpu_win && (streak != SMAX)) streak_nxt = streak + SW'(1);
      else                                  streak_nxt = streak;
    end
  end

  // State and streak registers; reset discards any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized traffic, all
// checked against a transaction-level model built on a shadow memory.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          aux_req, aux_we;
  logic [AW-1:0] aux_adr;
  logic [DW-1:0] aux_wdata;
  logic          aux_gnt, aux_rvalid;
  logic [DW-1:0] aux_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.DW(DW), .AW(AW), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_adr(cpu_adr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_adr(aux_adr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid),
    .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency (256 entries).
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_adr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_adr[7:0]];
    end
  end

  // Reference model: shadow memory plus what is due back next cycle.
  logic [DW-1:0] shadow [256];
  bit            m_cpu_due, m_aux_due;
  logic [DW-1:0] m_cpu_data, m_aux_data;
  int            m_streak;
  bit            last_stall;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Check one cycle of outputs against the model, then advance it.
  task automatic step();
    bit            act, forced, cg, ag, e_stall, e_en, e_we, e_gnt, e_rv;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wd, e_crd, e_ard;
    #1;
    cg = 0; ag = 0; e_stall = 0; e_en = 0; e_we = 0; e_gnt = 0; e_rv = 0;
    e_adr = '0; e_wd = '0; e_crd = '0; e_ard = '0;
    if (!reset) begin
      act    = (cpu_rd || cpu_wr) && !m_cpu_due;
      forced = aux_req && (m_streak >= MAXS);
      cg     = act && !forced;
      ag     = aux_req && !cg;
      if (cg) begin
        e_en = 1; e_we = cpu_wr; e_adr = cpu_adr; e_wd = cpu_wdata;
      end else if (ag) begin
        e_en = 1; e_we = aux_we; e_adr = aux_adr; e_wd = aux_wdata;
      end
      e_stall = act && !(cg && cpu_wr);
      e_gnt   = ag;
      e_rv    = m_aux_due;
      if (m_cpu_due) e_crd = m_cpu_data;
      if (m_aux_due) e_ard = m_aux_data;
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    chk("mem_adr", mem_adr, e_adr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_stall", cpu_stall, e_stall);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("aux_gnt", aux_gnt, e_gnt);
    chk("aux_rvalid", aux_rvalid, e_rv);
    chk("aux_rdata", aux_rdata, e_ard);
    last_stall = e_stall;
    @(posedge clk);
    if (reset) begin
      m_cpu_due = 0; m_aux_due = 0; m_streak = 0;
    end else begin
      m_cpu_due = cg && cpu_rd;
      m_aux_due = ag && !aux_we;
      if (cg) begin
        if (cpu_wr) shadow[cpu_adr[7:0]] = cpu_wdata;
        else        m_cpu_data = shadow[cpu_adr[7:0]];
      end
      if (ag) begin
        if (aux_we) shadow[aux_adr[7:0]] = aux_wdata;
        else        m_aux_data = shadow[aux_adr[7:0]];
      end
      if (!aux_req || ag)           m_streak = 0;
      else if (cg && m_streak < MAXS) m_streak = m_streak + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 32'hC0DE_0000 + i;
      shadow[i] = 32'hC0DE_0000 + i;
    end
    m_cpu_due = 0; m_aux_due = 0; m_streak = 0; last_stall = 0;
    m_cpu_data = '0; m_aux_data = '0;
    reset = 1; cpu_rd = 0; cpu_wr = 0; cpu_adr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_adr = '0; aux_wdata = '0;

    step(); step();
    reset = 0;
    step();

    // Reset in the middle of a CPU read.
    cpu_rd = 1; cpu_adr = 32'h10;
    settle(); chk("rd_issue_stall", cpu_stall, 1'b1);
    step();
    reset = 1;
    settle();
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_memen", mem_en, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    step();
    reset = 0; cpu_rd = 0;
    settle(); chk("post_rst_rdata", cpu_rdata, 32'h0);
    step();

    // Uncontended store then load.
    cpu_wr = 1; cpu_adr = 32'h20; cpu_wdata = 32'hDEADBEEF;
    settle();
    chk("st_we", mem_we, 1'b1);
    chk("st_stall", cpu_stall, 1'b0);
    step();
    cpu_wr = 0; cpu_rd = 1;
    settle(); chk("ld_stall", cpu_stall, 1'b1);
    step();
    settle();
    chk("ld_data", cpu_rdata, 32'hDEADBEEF);
    chk("ld_unstall", cpu_stall, 1'b0);
    step();
    cpu_rd = 0;

    // Contention and the starvation guard.
    aux_req = 1; aux_we = 0; aux_adr = 32'h20;
    for (int i = 0; i < MAXS; i++) begin
      cpu_wr = 1; cpu_adr = 32'h30 + 4 * i; cpu_wdata = i;
      settle();
      chk("streak_aux_gnt", aux_gnt, 1'b0);
      chk("streak_cpu_stall", cpu_stall, 1'b0);
      step();
    end
    cpu_adr = 32'h50; cpu_wdata = 32'h5050;
    settle();
    chk("forced_gnt", aux_gnt, 1'b1);
    chk("forced_stall", cpu_stall, 1'b1);
    chk("forced_adr", mem_adr, 32'h20);
    step();
    aux_req = 0;
    settle();
    chk("forced_rvalid", aux_rvalid, 1'b1);
    chk("forced_rdata", aux_rdata, 32'hDEADBEEF);
    chk("held_store_we", mem_we, 1'b1);
    step();
    cpu_wr = 0;

    // Pipelined CPU read and aux read.
    cpu_wr = 1; cpu_adr = 32'h40; cpu_wdata = 32'hA5A50040; step();
    cpu_adr = 32'h44; cpu_wdata = 32'h5A5A0044; step();
    cpu_wr = 0; cpu_rd = 1; cpu_adr = 32'h40; step();
    aux_req = 1; aux_we = 0; aux_adr = 32'h44;
    settle();
    chk("pipe_cpu_rdata", cpu_rdata, 32'hA5A50040);
    chk("pipe_aux_gnt", aux_gnt, 1'b1);
    step();
    cpu_rd = 0; aux_req = 0;
    settle();
    chk("pipe_aux_rvalid", aux_rvalid, 1'b1);
    chk("pipe_aux_rdata", aux_rdata, 32'h5A5A0044);
    step();

    // Aux write while the CPU is idle, read back by the CPU.
    aux_req = 1; aux_we = 1; aux_adr = 32'h80; aux_wdata = 32'h1234;
    settle();
    chk("auxw_gnt", aux_gnt, 1'b1);
    chk("auxw_we", mem_we, 1'b1);
    step();
    aux_req = 0; aux_we = 0;
    cpu_rd = 1; cpu_adr = 32'h80; step();
    settle(); chk("auxw_readback", cpu_rdata, 32'h1234);
    step();
    cpu_rd = 0;

    // Randomized traffic; the CPU holds its request while stalled.
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!last_stall) begin
        case ($urandom_range(0, 2))
          0: begin cpu_rd = 0; cpu_wr = 0; end
          1: begin cpu_rd = 1; cpu_wr = 0; end
          default: begin cpu_rd = 0; cpu_wr = 1; end
        endcase
        cpu_adr   = $urandom_range(0, 255);
        cpu_wdata = $urandom;
      end
      aux_req   = ($urandom_range(0, 2) != 0);
      aux_we    = $urandom_range(0, 1);
      aux_adr   = $urandom_range(0, 255);
      aux_wdata = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter placed between the Processor's data-memory interface (WriteData, DataAdr, ReadData, MemWrite, plus a read strobe) and one synchronous RAM port (1-cycle read latency). It shares the RAM with one auxiliary requester (program/data loader or display reader). The CPU has fixed priority. A bounded-streak rule guarantees aux progress. The CPU is stalled whenever its access cannot complete in the current cycle.

## Interface
Parameters:
- DW, 32, data width
- AW, 32, address width
- MAX_STREAK, 4, max consecutive CPU grants while aux is pending before aux is forced a slot (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_rd  in  1  CPU load request
- cpu_wr  in  1  CPU store request (MemWrite); cpu_rd & cpu_wr never both 1
- cpu_adr  in  AW  CPU address (DataAdr)
- cpu_wdata  in  DW  CPU store data (WriteData)
- cpu_rdata  out  DW  CPU load data (ReadData)
- cpu_stall  out  1  freeze CPU; the CPU holds its request stable while high
- aux_req  in  1  aux request
- aux_we  in  1  aux write (1) / read (0)
- aux_adr  in  AW  aux address
- aux_wdata  in  DW  aux write data
- aux_gnt  out  1  aux request accepted this cycle
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  DW  aux read data
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  RAM write
- mem_adr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after a read issue

## Operation
- FSM states:
  - IDLE: no read in flight.
  - CPU_RD: CPU read data is returning this cycle.
  - AUX_RD: aux read data is returning this cycle.
- Arbitration occurs every cycle. Candidates:
  - aux if aux_req.
  - CPU if (cpu_rd|cpu_wr) and state≠CPU_RD. In CPU_RD, the CPU's request is being completed, not re-issued.
- Winner rules:
  - CPU wins unless aux_req & streak==MAX_STREAK.
  - The winner drives mem_en=1, mem_we, mem_adr, mem_wdata.
  - With no winner: mem_en=mem_we=0, mem_adr=mem_wdata=0.
- streak counter:
  - Increments on each CPU grant while aux_req=1.
  - Clears when aux is granted or aux_req=0.
  - Saturates at MAX_STREAK.
- CPU write granted: the write completes that cycle; cpu_stall=0; the state is unaffected by the CPU.
- CPU read granted: cpu_stall=1. Next state is CPU_RD. In CPU_RD: cpu_stall=0, cpu_rdata=mem_rdata.
- CPU requesting but not granted (aux wins): cpu_stall=1.
- Aux granted: aux_gnt=1 for one cycle. Aux may change its request the next cycle.
  - Aux read: next state is AUX_RD. In AUX_RD: aux_rvalid=1, aux_rdata=mem_rdata.
- Next state:
  - CPU_RD if a CPU read was granted.
  - Else AUX_RD if an aux read was granted.
  - Else IDLE.
- cpu_rdata is 0 outside CPU_RD. aux_rdata is 0 when aux_rvalid=0.

## Timing
- Reset (synchronous, any state, including mid-read):
  - Next edge: state=IDLE, streak=0. Any in-flight read data is discarded (no rvalid, no un-stall from it).
  - While reset=1: mem_en=mem_we=0, mem_adr=mem_wdata=0, cpu_stall=0, aux_gnt=0, aux_rvalid=0, cpu_rdata=aux_rdata=0.
- CPU write latency: 0 stall cycles when uncontended.
- CPU read latency: 1 stall cycle; data is returned in the second cycle.
- Aux read: aux_rvalid arrives exactly 1 cycle after aux_gnt.
- The CPU_RD and AUX_RD return cycles are also issue cycles. Back-to-back reads are fully pipelined at 1 access per cycle.
- Worst-case added CPU wait from aux: 1 cycle per MAX_STREAK CPU grants.
- Worst-case aux wait: MAX_STREAK+1 cycles.
- All outputs are combinational from state, streak, and inputs. Only state and streak are registered.

## Test plan
- Reset mid-read: issue a CPU read at 0x10, then assert reset in the CPU_RD cycle. Required: cpu_stall=0 and all mem_*=0 during reset; state IDLE afterwards; no stale cpu_rdata.
- Uncontended CPU: store 0xDEADBEEF to 0x20, then load 0x20. Required:
  - Store cycle: mem_we=1, cpu_stall=0.
  - Load: cpu_stall=1 for one cycle, then cpu_rdata=0xDEADBEEF with cpu_stall=0.
- Simultaneous requests, streak=0: CPU write and aux read in the same cycle. Required: CPU granted; aux_gnt=0; streak=1.
- Starvation guard: MAX_STREAK=4, aux_req held high with continuous CPU stores. Required:
  - Four CPU grants.
  - Fifth cycle: aux_gnt=1, cpu_stall=1, mem_adr=aux_adr.
  - streak returns to 0.
- Pipelined reads: CPU load 0x40 is granted; in its CPU_RD cycle an aux read of 0x44 is granted. Required:
  - CPU_RD cycle: cpu_rdata=RAM[0x40] and aux_gnt=1, same cycle.
  - Next cycle: aux_rvalid=1, aux_rdata=RAM[0x44].
- Aux write during CPU idle: aux_req=1, aux_we=1, adr 0x80, data 0x1234. Required: aux_gnt=1 and mem_we=1 the same cycle; a later CPU load of 0x80 returns 0x1234.
